data_mem_hs: RTL and testbench

- Parametrised successor to the 64x32 synchronous data memory.
- Byte-addressed, with byte/half/full-word loads and stores, sign extension and a configurable number of wait states.
- Uses a valid/ready request–response handshake so the pipeline MEM stage can stall on it.
- Single outstanding request. Memory storage is internal.

---
 rtl/data_mem_hs.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_hs.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with valid/ready request/response handshake and wait states.
// Define DMEM_ALIGN_CHECK_EN to report misaligned half/full accesses as errors.
module data_mem_hs #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned IDX_W  = ADDR_W - LANE_W;
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;
  logic                enter_resp;

  logic                write_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [IDX_W-1:0]    idx;
  logic [LANE_W-1:0]   off;
  logic [LANE_W-1:0]   off_eff;
  logic [LANE_W+2:0]   shamt;
  logic                oob;
  logic                misalign;
  logic                err_d;
  logic [LANES-1:0]    be;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   wr_shift;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   load_val;

  // Handshake FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? StResp : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  assign idx = addr_q[ADDR_W-1:LANE_W];
  assign off = addr_q[LANE_W-1:0];
  assign oob = (32'(idx) >= DEPTH);

  // Lane selection; without the align check, low offset bits snap to natural alignment
  always_comb begin
    off_eff  = off;
    misalign = 1'b0;
    be       = '0;
    unique case (size_q)
      2'b00: be = LANES'(1) << off;
      2'b01: begin
        misalign = off[0];
        off_eff  = off & ~LANE_W'(1);
        be       = LANES'(3) << off_eff;
      end
      2'b10: begin
        misalign = |off;
        off_eff  = '0;
        be       = '1;
      end
      default: be = '0;
    endcase
  end

  assign err_d    = oob || (size_q == 2'b11) || (AlignCheck && misalign);
  assign shamt    = {off_eff, 3'b000};
  assign rd_word  = oob ? '0 : mem_q[idx];
  assign rd_shift = rd_word >> shamt;
  assign wr_shift = wdata_q << shamt;

  always_comb begin
    merged = rd_word;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (be[l]) begin
        merged[l*8 +: 8] = wr_shift[l*8 +: 8];
      end
    end
  end

  always_comb begin
    load_val = '0;
    unique case (size_q)
      2'b00: load_val = {{(DATA_W-8){signed_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01: load_val = {{(DATA_W-16){signed_q & rd_shift[15]}}, rd_shift[15:0]};
      2'b10: load_val = rd_shift;
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      // Memory is touched only on the edge that enters the response state
      if (enter_resp) begin
        err_q   <= err_d;
        rdata_q <= (write_q || err_d) ? '0 : load_val;
        if (write_q && !err_d) begin
          mem_q[idx] <= merged;
        end
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs: directed table, corner sequences, random vs byte model.
module tb_data_mem_hs;

  localparam int WAIT  = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int checks   = 0;
  int failures = 0;

  data_mem_hs #(
    .DATA_W      (32),
    .DEPTH       (DEPTH),
    .ADDR_W      (8),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Byte-level reference memory
  bit [7:0] mbytes [256];

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) mbytes[i] = (i % 4 == 0) ? 8'(i / 4) : 8'h00;
  endfunction

  function automatic void model_txn(input bit wr, input bit [1:0] sz, input bit sg,
                                    input bit [7:0] addr, input bit [31:0] wd,
                                    output bit [31:0] rd, output bit er);
    int nbytes, base;
    bit mis;
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    mis = (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0);
    er = (sz == 3) || (int'(addr) / 4 >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    er = er || mis;
`endif
    rd = 0;
    if (er) return;
    base = int'(addr) - (int'(addr) % nbytes);
    if (wr) begin
      for (int i = 0; i < nbytes; i++) mbytes[base + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nbytes; i++) rd[8*i +: 8] = mbytes[base + i];
      if (sg && sz == 0 && rd[7]) rd = rd | 32'hFFFF_FF00;
      if (sg && sz == 1 && rd[15]) rd = rd | 32'hFFFF_0000;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit wr, input bit [1:0] sz, input bit sg,
                           input bit [7:0] addr, input bit [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  // Full transaction: checks latency, req_ready low while busy, and return to idle
  task automatic txn(input string name, input bit wr, input bit [1:0] sz, input bit sg,
                     input bit [7:0] addr, input bit [31:0] wd, input int stall,
                     output logic [31:0] rd, output logic er);
    int n;
    bit ready_seen;
    @(negedge clk);
    drive_req(wr, sz, sg, addr, wd);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    n          = 1;
    ready_seen = 1'b0;
    while (!resp_valid && n < 50) begin
      if (req_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, WAIT + 1);
    check({name, "_ready_busy"}, {31'b0, ready_seen}, 32'd0);
    rd = resp_rdata;
    er = resp_err;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({name, "_idle"}, {30'b0, req_ready, resp_valid}, 32'b10);
  endtask

  typedef struct {
    string       name;
    bit          wr;
    bit [1:0]    sz;
    bit          sg;
    bit [7:0]    addr;
    bit [31:0]   wd;
    bit [31:0]   exp_rd;
    bit          exp_er;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input bit wr, input bit [1:0] sz, input bit sg,
                         input bit [7:0] addr, input bit [31:0] wd,
                         input bit [31:0] exp_rd, input bit exp_er);
    vec_t v;
    v.name = name; v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_er = exp_er;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    bit   [31:0] mrd;
    bit          mer;
    bit          flag;
    int          n;

    add_vec("ld_full_14",    0, 2'd2, 0, 8'h14, 32'h0,         32'h0000_0005, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    add_vec("ld_full_16",    0, 2'd2, 0, 8'h16, 32'h0,         32'h0,         1);
`else
    add_vec("ld_full_16",    0, 2'd2, 0, 8'h16, 32'h0,         32'h0000_0005, 0);
`endif
    add_vec("ld_size3",      0, 2'd3, 0, 8'h10, 32'h0,         32'h0,         1);
    add_vec("st_size3",      1, 2'd3, 0, 8'h10, 32'hFFFF_FFFF, 32'h0,         1);
    add_vec("ld_full_10",    0, 2'd2, 0, 8'h10, 32'h0,         32'h0000_0004, 0);
    add_vec("st_byte_15",    1, 2'd0, 0, 8'h15, 32'h0000_00AB, 32'h0,         0);
    add_vec("ld_full_14b",   0, 2'd2, 0, 8'h14, 32'h0,         32'h0000_AB05, 0);
    add_vec("ld_byte_s_15",  0, 2'd0, 1, 8'h15, 32'h0,         32'hFFFF_FFAB, 0);
    add_vec("ld_byte_u_15",  0, 2'd0, 0, 8'h15, 32'h0,         32'h0000_00AB, 0);
    add_vec("st_half_22",    1, 2'd1, 0, 8'h22, 32'h0000_8001, 32'h0,         0);
    add_vec("ld_half_s_22",  0, 2'd1, 1, 8'h22, 32'h0,         32'hFFFF_8001, 0);
    add_vec("ld_full_20",    0, 2'd2, 0, 8'h20, 32'h0,         32'h8001_0008, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    add_vec("ld_half_u_23",  0, 2'd1, 0, 8'h23, 32'h0,         32'h0,         1);
    add_vec("st_full_0e",    1, 2'd2, 0, 8'h0E, 32'h1122_3344, 32'h0,         1);
    add_vec("ld_full_0c",    0, 2'd2, 0, 8'h0C, 32'h0,         32'h0000_0003, 0);
`else
    add_vec("ld_half_u_23",  0, 2'd1, 0, 8'h23, 32'h0,         32'h0000_8001, 0);
    add_vec("st_full_0e",    1, 2'd2, 0, 8'h0E, 32'h1122_3344, 32'h0,         0);
    add_vec("ld_full_0c",    0, 2'd2, 0, 8'h0C, 32'h0,         32'h1122_3344, 0);
`endif

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready",      {31'b0, req_ready},  32'd1);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_rdata",      resp_rdata,          32'd0);
    check("reset_err",        {31'b0, resp_err},   32'd0);

    // Directed table
    foreach (vecs[i]) begin
      txn(vecs[i].name, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd, 0, rd, er);
      model_txn(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd, mrd, mer);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, "_err"}, {31'b0, er}, {31'b0, vecs[i].exp_er});
    end

    // Response back-pressure with req_valid held high
    model_txn(0, 2'd2, 0, 8'h14, 32'h0, mrd, mer);
    @(negedge clk);
    drive_req(0, 2'd2, 0, 8'h14, 32'h0);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("stall_valid", {31'b0, resp_valid}, 32'd1);
      check("stall_rdata", resp_rdata, mrd);
      check("stall_err",   {31'b0, resp_err}, {31'b0, mer});
      check("stall_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("stall_release_idle", {30'b0, req_ready, resp_valid}, 32'b10);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("stall_reaccept", {31'b0, req_ready}, 32'd0);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_second_rdata", resp_rdata, mrd);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;

    // Reset while a store is in flight: store must be dropped
    @(negedge clk);
    drive_req(1, 2'd2, 0, 8'h08, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_busy_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) flag = 1'b1;
      @(posedge clk);
      #1;
    end
    check("rst_no_resp", {31'b0, flag}, 32'd0);
    check("rst_idle", {31'b0, req_ready}, 32'd1);
    txn("rst_ld_08", 0, 2'd2, 0, 8'h08, 32'h0, 0, rd, er);
    check("rst_ld_08_rdata", rd, 32'h0000_0002);

    // Randomized traffic against the byte model
    for (int t = 0; t < 300; t++) begin
      bit        wr, sg;
      bit [1:0]  sz;
      bit [7:0]  addr;
      bit [31:0] wd;
      wr   = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sg   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 255));
      wd   = $urandom;
      txn("rnd", wr, sz, sg, addr, wd, $urandom_range(0, 2), rd, er);
      model_txn(wr, sz, sg, addr, wd, mrd, mer);
      check("rnd_rdata", rd, mrd);
      check("rnd_err", {31'b0, er}, {31'b0, mer});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
